// File: rtl/light_pkg.sv
// Pattern encodings and request priority decode, reused by the taillight sequencing FSM.
package light_pkg;

  localparam logic [1:0] LR_OFF    = 2'b00;
  localparam logic [1:0] LR_LEFT   = 2'b10;
  localparam logic [1:0] LR_RIGHT  = 2'b01;
  localparam logic [1:0] LR_HAZARD = 2'b11;

  // The state encoding doubles as the lr pattern select.
  typedef enum logic [1:0] {
    StIdle   = LR_OFF,
    StLeft   = LR_LEFT,
    StRight  = LR_RIGHT,
    StHazard = LR_HAZARD
  } light_state_e;

  // Priority hazard > left > right; LR_OFF means no valid request.
  function automatic logic [1:0] prio_decode(input logic left, input logic right,
                                             input logic hazard, input logic hazard_en);
    if (hazard_en && (hazard || (left && right))) return LR_HAZARD;
    if (left && right) return LR_OFF;
    if (left) return LR_LEFT;
    if (right) return LR_RIGHT;
    return LR_OFF;
  endfunction

  function automatic logic [1:0] prio_rank(input logic [1:0] lr);
    case (lr)
      LR_HAZARD: return 2'd3;
      LR_LEFT:   return 2'd2;
      LR_RIGHT:  return 2'd1;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running step-tick divider: tick_o is high for one clk every Div clks.
module tick_gen #(
  parameter int unsigned Div = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/turn_signal_sched.sv
// Turn-signal scheduler: paces the light FSM and applies prioritised requests on sweep boundaries.
// Define TURN_SIGNAL_HAZARD_EN to enable the hazard pattern (req_hazard_i, left+right -> hazard).
module turn_signal_sched
  import light_pkg::*;
#(
  parameter int unsigned Div       = 25_000_000,
  parameter int unsigned SweepLen  = 4,
  parameter int unsigned MaxSweeps = 8,
  localparam int unsigned PhaseW   = ($clog2(SweepLen) > 2) ? $clog2(SweepLen) : 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_left_i,
  input  logic              req_right_i,
  input  logic              req_hazard_i,
  input  logic              cancel_i,
  output logic              tick_o,
  output logic [1:0]        lr_o,
  output logic [PhaseW-1:0] phase_o,
  output logic              sweep_done_o,
  output logic              busy_o
);

`ifdef TURN_SIGNAL_HAZARD_EN
  localparam logic HazardEn = 1'b1;
`else
  localparam logic HazardEn = 1'b0;
`endif

  localparam int unsigned SweepW = (MaxSweeps > 1) ? $clog2(MaxSweeps) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(SweepLen - 1);
  localparam logic [SweepW-1:0] SweepLast = SweepW'(MaxSweeps - 1);

  light_state_e      state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [SweepW-1:0] sweeps_q, sweeps_d;
  logic [1:0]        pend_q, pend_d;
  logic              cancel_pend_q, cancel_pend_d;
  logic              tick, wrap, cur_req;
  logic [1:0]        req_lr;

  tick_gen #(
    .Div(Div)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tick_o(tick)
  );

  assign req_lr = prio_decode(req_left_i, req_right_i, req_hazard_i, HazardEn);
  assign wrap   = tick && (state_q != StIdle) && (phase_q == PhaseLast);

  always_comb begin
    case (state_q)
      StLeft:   cur_req = req_left_i;
      StRight:  cur_req = req_right_i;
      StHazard: cur_req = HazardEn & (req_hazard_i | (req_left_i & req_right_i));
      default:  cur_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    sweeps_d      = sweeps_q;
    pend_d        = pend_q;
    cancel_pend_d = cancel_pend_q;

    if (tick) begin
      if (state_q == StIdle) begin
        cancel_pend_d = 1'b0;
        if (pend_q != LR_OFF) begin
          state_d  = light_state_e'(pend_q);
          phase_d  = '0;
          sweeps_d = '0;
          pend_d   = LR_OFF;
        end
      end else if (wrap) begin
        phase_d = '0;
        if (cancel_pend_q) begin
          state_d       = StIdle;
          cancel_pend_d = 1'b0;
        end else if ((pend_q != LR_OFF) && (pend_q != state_q)) begin
          state_d  = light_state_e'(pend_q);
          sweeps_d = '0;
          pend_d   = LR_OFF;
        end else if (cur_req) begin
          sweeps_d = '0;
        end else if (sweeps_q == SweepLast) begin
          state_d = StIdle;
        end else begin
          sweeps_d = sweeps_q + 1'b1;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    // Latch after the boundary decision; a request for the pattern already running is not pending.
    if (cancel_i) begin
      pend_d        = LR_OFF;
      cancel_pend_d = 1'b1;
    end else if ((req_lr != LR_OFF) && (req_lr != state_d) &&
                 (prio_rank(req_lr) > prio_rank(pend_d))) begin
      pend_d = req_lr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      sweeps_q      <= '0;
      pend_q        <= LR_OFF;
      cancel_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      sweeps_q      <= sweeps_d;
      pend_q        <= pend_d;
      cancel_pend_q <= cancel_pend_d;
    end
  end

  assign tick_o       = tick;
  assign lr_o         = state_q;
  assign phase_o      = phase_q;
  assign sweep_done_o = wrap;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_turn_signal_sched.sv
// Directed bench for turn_signal_sched with Div=4, SweepLen=4, MaxSweeps=2.
module tb_turn_signal_sched;

  localparam int unsigned Div       = 4;
  localparam int unsigned SweepLen  = 4;
  localparam int unsigned MaxSweeps = 2;

`ifdef TURN_SIGNAL_HAZARD_EN
  localparam bit HazEn = 1'b1;
`else
  localparam bit HazEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_left = 1'b0, req_right = 1'b0, req_hazard = 1'b0, cancel = 1'b0;
  logic       tick, sweep_done, busy;
  logic [1:0] lr, phase;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  turn_signal_sched #(
    .Div      (Div),
    .SweepLen (SweepLen),
    .MaxSweeps(MaxSweeps)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_left_i  (req_left),
    .req_right_i (req_right),
    .req_hazard_i(req_hazard),
    .cancel_i    (cancel),
    .tick_o      (tick),
    .lr_o        (lr),
    .phase_o     (phase),
    .sweep_done_o(sweep_done),
    .busy_o      (busy)
  );

  // Called at a negedge: waits for a tick-high cycle, lets its edge pass, returns at the next negedge.
  task automatic tick_step(output logic sd);
    int n = 0;
    sd = 1'b0;
    while (tick !== 1'b1 && n < 3 * Div) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: no tick within %0d clks", 3 * Div);
    end
    sd = sweep_done;
    @(negedge clk);
  endtask

  task automatic pulse(input bit l, input bit r, input bit h, input bit c);
    req_left = l; req_right = r; req_hazard = h; cancel = c;
    @(negedge clk);
    req_left = 0; req_right = 0; req_hazard = 0; cancel = 0;
  endtask

  task automatic drain_cancel();
    logic sd;
    pulse(0, 0, 0, 1);
    for (int i = 0; i < 10 && lr !== 2'b00; i++) tick_step(sd);
    if (lr !== 2'b00) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: lr=%b required=00", lr);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({tick, lr, phase, sweep_done, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000000", {tick, lr, phase, sweep_done, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      checks++;
      if (tick !== ((n % 4) == 3)) begin
        failures++;
        $display("FAIL idle_tick n=%0d: got %b required %b", n, tick, (n % 4) == 3);
      end
      checks++;
      if ({lr, phase, sweep_done, busy} !== 6'b0) begin
        failures++;
        $display("FAIL idle_outputs n=%0d: got %b required 000000", n, {lr, phase, sweep_done, busy});
      end
    end
  endtask

  task automatic test_left_pulse();
    logic sd;
    int sd_count = 0;
    logic [1:0] exp_lr, exp_ph;
    pulse(1, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      tick_step(sd);
      sd_count += int'(sd);
      exp_lr = (i == 8) ? 2'b00 : 2'b10;
      exp_ph = (i == 8) ? 2'd0 : 2'(i % 4);
      checks++;
      if (lr !== exp_lr || phase !== exp_ph || busy !== (exp_lr != 2'b00)) begin
        failures++;
        $display("FAIL left_step i=%0d: got lr=%b ph=%0d busy=%b required lr=%b ph=%0d",
                 i, lr, phase, busy, exp_lr, exp_ph);
      end
    end
    checks++;
    if (sd_count != 2) begin
      failures++;
      $display("FAIL left_sweep_done: got %0d pulses required 2", sd_count);
    end
  endtask

  task automatic test_switch();
    logic sd;
    pulse(1, 0, 0, 0);
    tick_step(sd);
    tick_step(sd);
    pulse(0, 1, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      tick_step(sd);
      checks++;
      if (lr !== ((i == 4) ? 2'b01 : 2'b10) || phase !== 2'(i % 4)) begin
        failures++;
        $display("FAIL switch_step i=%0d: got lr=%b ph=%0d required lr=%b ph=%0d",
                 i, lr, phase, (i == 4) ? 2'b01 : 2'b10, i % 4);
      end
    end
    drain_cancel();
  endtask

  task automatic test_hazard();
    logic sd;
    logic [1:0] exp_lr;
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick_step(sd);
    pulse(0, 0, 1, 0);
    tick_step(sd);
    checks++;
    if (lr !== 2'b10 || phase !== 2'd3) begin
      failures++;
      $display("FAIL hazard_hold: got lr=%b ph=%0d required lr=10 ph=3", lr, phase);
    end
    tick_step(sd);
    exp_lr = HazEn ? 2'b11 : 2'b10;
    checks++;
    if (lr !== exp_lr || phase !== 2'd0) begin
      failures++;
      $display("FAIL hazard_wrap: got lr=%b ph=%0d required lr=%b ph=0", lr, phase, exp_lr);
    end
    drain_cancel();
    pulse(1, 1, 0, 0);
    tick_step(sd);
    exp_lr = HazEn ? 2'b11 : 2'b00;
    checks++;
    if (lr !== exp_lr) begin
      failures++;
      $display("FAIL left_right_combo: got lr=%b required %b", lr, exp_lr);
    end
    drain_cancel();
  endtask

  task automatic test_cancel();
    logic sd;
    req_right = 1'b1;
    tick_step(sd);
    tick_step(sd);
    checks++;
    if (lr !== 2'b01 || phase !== 2'd1) begin
      failures++;
      $display("FAIL cancel_grant: got lr=%b ph=%0d required lr=01 ph=1", lr, phase);
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    tick_step(sd);
    tick_step(sd);
    checks++;
    if (lr !== 2'b01 || phase !== 2'd3) begin
      failures++;
      $display("FAIL cancel_hold: got lr=%b ph=%0d required lr=01 ph=3", lr, phase);
    end
    req_right = 1'b0;
    tick_step(sd);
    checks++;
    if (lr !== 2'b00 || phase !== 2'd0 || busy !== 1'b0 || sd !== 1'b1) begin
      failures++;
      $display("FAIL cancel_wrap: got lr=%b ph=%0d busy=%b sd=%b required lr=00 ph=0 busy=0 sd=1",
               lr, phase, busy, sd);
    end
    pulse(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick_step(sd);
      checks++;
      if (lr !== 2'b00) begin
        failures++;
        $display("FAIL cancel_beats_req i=%0d: got lr=%b required 00", i, lr);
      end
    end
    // A later grant must not inherit the stale cancel; it runs its full MaxSweeps.
    pulse(1, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      tick_step(sd);
      if (i == 4 || i == 8) begin
        checks++;
        if (lr !== ((i == 8) ? 2'b00 : 2'b10)) begin
          failures++;
          $display("FAIL post_cancel_run i=%0d: got lr=%b required %b",
                   i, lr, (i == 8) ? 2'b00 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic sd;
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick_step(sd);
    checks++;
    if (lr !== 2'b10 || phase !== 2'd2) begin
      failures++;
      $display("FAIL midreset_setup: got lr=%b ph=%0d required lr=10 ph=2", lr, phase);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lr, phase, busy, sweep_done, tick} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_async: got %b required 0000000", {lr, phase, busy, sweep_done, tick});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick_step(sd);
    checks++;
    if (lr !== 2'b00 || sd !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after: got lr=%b sd=%b required lr=00 sd=0", lr, sd);
    end
  endtask

  initial begin
    test_reset();
    test_left_pulse();
    test_switch();
    test_hazard();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
